// File: rtl/sensor_debounce.sv
// ---------------------------------------------------------------------------
// sensor_debounce
//   Input conditioning for CH raw, asynchronous, bouncy sensor lines.
//   Each line passes through a 2-flop synchroniser and a stability counter,
//   and then drives an edge detector. The alarm FSM downstream only sees
//   clean levels, one-cycle rise/fall pulses and an active-sensor count.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   ena         stage enable; 0 freezes counters and levels (sync keeps sampling)
//   sensor_raw  raw asynchronous sensor lines            [CH]
//   sensor_o    debounced sensor levels                  [CH]
//   rise_o      one-cycle pulse on sensor_o 0->1         [CH]
//   fall_o      one-cycle pulse on sensor_o 1->0         [CH]
//   any_active  OR of sensor_o
//   active_cnt  popcount of sensor_o                     [CNT_OUT_W]
//
// Parameters
//   CH         number of channels
//   STABLE     cycles a synchronised level must persist (2..255)
//   CNT_W      stability counter width, 2**CNT_W > STABLE-1
//   CNT_OUT_W  active_cnt width, 2**CNT_OUT_W > CH
// ---------------------------------------------------------------------------
module sensor_debounce #(
  parameter int CH        = 8,
  parameter int STABLE    = 8,
  parameter int CNT_W     = 8,
  parameter int CNT_OUT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [CH-1:0]        sensor_raw,
  output logic [CH-1:0]        sensor_o,
  output logic [CH-1:0]        rise_o,
  output logic [CH-1:0]        fall_o,
  output logic                 any_active,
  output logic [CNT_OUT_W-1:0] active_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

  logic [CH-1:0]    s1_q;
  logic [CH-1:0]    s2_q;
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];
  logic [CH-1:0]    sensor_q, sensor_d;
  logic [CH-1:0]    rise_q,   rise_d;
  logic [CH-1:0]    fall_q,   fall_d;

  // Debounce next-state logic, one independent lane per channel.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    sensor_d = sensor_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ena) begin
        if (s2_q[i] == sensor_q[i]) begin
          // Back at the accepted level: any partial count is a bounce.
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= CNT_MAX) begin
          // Mismatch has persisted STABLE cycles: accept and flag the edge.
          sensor_d[i] = s2_q[i];
          cnt_d[i]    = '0;
          rise_d[i]   = s2_q[i];
          fall_d[i]   = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      // ena=0: counter and level hold, pulses drop to 0 via the defaults.
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      sensor_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      // NOTE: the counter array is plain flops, not a RAM, so it is reset
      // with everything else; a stale partial count must not survive reset.
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make s2 take the old s1, giving a
      // true two-stage synchroniser rather than a single collapsed flop.
      s1_q     <= sensor_raw;
      s2_q     <= s1_q;
      sensor_q <= sensor_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Summary outputs decode the registered level only, so they settle right
  // after the edge and stay glitch-free for the rest of the cycle.
  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < CH; i++) begin
      active_cnt = active_cnt + CNT_OUT_W'(sensor_q[i]);
    end
  end

  assign any_active = |sensor_q;
  assign sensor_o   = sensor_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;

endmodule

// File: tb/tb_sensor_debounce.sv
// ---------------------------------------------------------------------------
// tb_sensor_debounce
//   Directed bench for sensor_debounce at default parameters (CH=8,
//   STABLE=8). A new raw level applied between edges is first sampled by
//   edge 1 and accepted on edge 10.
// ---------------------------------------------------------------------------
module tb_sensor_debounce;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] sensor_raw;
  logic [7:0] sensor_o;
  logic [7:0] rise_o;
  logic [7:0] fall_o;
  logic       any_active;
  logic [3:0] active_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse / level watchers accumulated by tick_watch.
  int w_rise;
  int w_fall;
  int w_high;

  typedef struct {
    logic [7:0] raw;
    int         cycles;
    logic [7:0] sensor;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [3:0] cnt;
    logic       any;
  } vec_t;

  vec_t vecs [8];

  sensor_debounce dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .sensor_raw (sensor_raw),
    .sensor_o   (sensor_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .any_active (any_active),
    .active_cnt (active_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns for sampling/driving.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n edges while counting pulses on any channel and cycles where
  // channel ch reads high.
  task automatic tick_watch(input int n, input int ch);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rise_o != 8'h00) w_rise++;
      if (fall_o != 8'h00) w_fall++;
      if (sensor_o[ch]) w_high++;
    end
  endtask

  task automatic clear_watch();
    w_rise = 0;
    w_fall = 0;
    w_high = 0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    ena        = 1'b1;
    sensor_raw = 8'h00;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    // Multi-channel table: run `cycles` edges with `raw`, then compare.
    vecs[0] = '{raw: 8'h06, cycles: 9,  sensor: 8'h00, rise: 8'h00, fall: 8'h00, cnt: 4'd0, any: 1'b0};
    vecs[1] = '{raw: 8'h06, cycles: 1,  sensor: 8'h06, rise: 8'h06, fall: 8'h00, cnt: 4'd2, any: 1'b1};
    vecs[2] = '{raw: 8'h06, cycles: 1,  sensor: 8'h06, rise: 8'h00, fall: 8'h00, cnt: 4'd2, any: 1'b1};
    vecs[3] = '{raw: 8'h06, cycles: 28, sensor: 8'h06, rise: 8'h00, fall: 8'h00, cnt: 4'd2, any: 1'b1};
    vecs[4] = '{raw: 8'hFF, cycles: 10, sensor: 8'hFF, rise: 8'hF9, fall: 8'h00, cnt: 4'd8, any: 1'b1};
    vecs[5] = '{raw: 8'hFF, cycles: 1,  sensor: 8'hFF, rise: 8'h00, fall: 8'h00, cnt: 4'd8, any: 1'b1};
    vecs[6] = '{raw: 8'h00, cycles: 10, sensor: 8'h00, rise: 8'h00, fall: 8'hFF, cnt: 4'd0, any: 1'b0};
    vecs[7] = '{raw: 8'h00, cycles: 1,  sensor: 8'h00, rise: 8'h00, fall: 8'h00, cnt: 4'd0, any: 1'b0};

    // 1. Reset held with all lines high, then asynchronous reset mid-cycle.
    rst        = 1'b1;
    ena        = 1'b1;
    sensor_raw = 8'hFF;
    tick(3);
    check("rst_sensor", sensor_o,   8'h00);
    check("rst_rise",   rise_o,     8'h00);
    check("rst_fall",   fall_o,     8'h00);
    check("rst_any",    any_active, 1'b0);
    check("rst_cnt",    active_cnt, 4'd0);
    rst = 1'b0;
    tick(9);
    check("rst_rel_e9",  sensor_o,   8'h00);
    tick(1);
    check("rst_rel_e10", sensor_o,   8'hFF);
    check("rst_rel_cnt", active_cnt, 4'd8);
    #2 rst = 1'b1;
    #1;
    check("async_sensor", sensor_o,   8'h00);
    check("async_rise",   rise_o,     8'h00);
    check("async_any",    any_active, 1'b0);
    check("async_cnt",    active_cnt, 4'd0);

    // 2. Clean press on channel 0.
    do_reset();
    sensor_raw = 8'h01;
    tick(9);
    check("press_e9",     sensor_o,   8'h00);
    tick(1);
    check("press_e10",    sensor_o,   8'h01);
    check("press_rise",   rise_o,     8'h01);
    check("press_cnt",    active_cnt, 4'd1);
    tick(1);
    check("press_rise_1", rise_o,     8'h00);
    tick(9);
    sensor_raw = 8'h00;
    tick(9);
    check("rel_e9",       sensor_o,   8'h01);
    tick(1);
    check("rel_e10",      sensor_o,   8'h00);
    check("rel_fall",     fall_o,     8'h01);
    check("rel_cnt",      active_cnt, 4'd0);
    tick(1);
    check("rel_fall_1",   fall_o,     8'h00);

    // 3. Short glitch, then bounce train, then steady high on channel 1.
    do_reset();
    clear_watch();
    sensor_raw = 8'h02;
    tick_watch(5, 1);
    sensor_raw = 8'h00;
    tick_watch(15, 1);
    check("glitch_pulses", w_rise + w_fall, 0);
    check("glitch_high",   w_high,          0);
    clear_watch();
    for (int k = 0; k < 10; k++) begin
      sensor_raw[1] = ~sensor_raw[1];
      tick_watch(3, 1);
    end
    check("bounce_pulses", w_rise + w_fall, 0);
    check("bounce_high",   w_high,          0);
    sensor_raw = 8'h02;
    tick(9);
    check("bounce_e9",     sensor_o, 8'h00);
    tick(1);
    check("bounce_e10",    sensor_o, 8'h02);
    check("bounce_rise",   rise_o,   8'h02);
    clear_watch();
    tick_watch(10, 1);
    check("bounce_extra",  w_rise + w_fall, 0);
    check("bounce_hold",   w_high,          10);

    // 4. Multi-channel table.
    do_reset();
    for (int v = 0; v < 8; v++) begin
      sensor_raw = vecs[v].raw;
      tick(vecs[v].cycles);
      check($sformatf("vec%0d_sensor", v), sensor_o,   vecs[v].sensor);
      check($sformatf("vec%0d_rise",   v), rise_o,     vecs[v].rise);
      check($sformatf("vec%0d_fall",   v), fall_o,     vecs[v].fall);
      check($sformatf("vec%0d_cnt",    v), active_cnt, vecs[v].cnt);
      check($sformatf("vec%0d_any",    v), any_active, vecs[v].any);
    end

    // 5. Enable freeze on channel 2 after 3 counts.
    do_reset();
    sensor_raw = 8'h04;
    tick(5);
    ena = 1'b0;
    clear_watch();
    tick_watch(20, 2);
    check("ena_pulses", w_rise + w_fall, 0);
    check("ena_high",   w_high,          0);
    ena = 1'b1;
    tick(4);
    check("ena_e4",     sensor_o, 8'h00);
    tick(1);
    check("ena_e5",     sensor_o, 8'h04);
    check("ena_rise",   rise_o,   8'h04);

    // 6. Reset mid-count on channel 3.
    do_reset();
    sensor_raw = 8'h08;
    tick(6);
    rst = 1'b1;
    tick(1);
    check("midrst_held", sensor_o, 8'h00);
    rst = 1'b0;
    tick(9);
    check("midrst_e9",   sensor_o, 8'h00);
    tick(1);
    check("midrst_e10",  sensor_o, 8'h08);
    check("midrst_rise", rise_o,   8'h08);
    clear_watch();
    tick_watch(5, 3);
    check("midrst_single", w_rise, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
